// File: rtl/slice_serial_adder_pkg.sv
// Shared definitions for the slice-serial adder.
//   state_e   : controller states (IDLE/RUN/DONE keep their original 0/1/2 codes)
//   clog2     : ceiling log2, for constant width calculations
//   idx_width : slice-index width, never less than one bit
package slice_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned idx_width(input int unsigned w);
    return (clog2(w) < 1) ? 1 : clog2(w);
  endfunction

endpackage

// File: rtl/slice_serial_adder_if.sv
// Handshake bundle for slice_serial_adder.
//   in_valid/in_ready/in_a/in_b/in_cin : operand request (producer -> adder)
//   out_valid/out_ready/out_sum/out_cout/out_ovf : result (adder -> consumer)
//   busy : adder is in RUN or DONE
// master = producer/consumer side, slave = adder side.
interface slice_serial_adder_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_a;
  logic [N*W-1:0]   in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [N*W-1:0]   out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );
endinterface

// File: rtl/slice_serial_adder_rca.sv
// N-bit ripple-carry adder, purely combinational.
//   a, b  : addends
//   cin   : carry into bit 0
//   sum   : a + b + cin (mod 2^N)
//   cout  : carry out of every bit position; cout[N-1] is the adder carry-out,
//           cout[N-2] is the carry into the MSB
module rca #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic [N-1:0] cout
);

  always_comb begin
    logic c;
    sum  = '0;
    cout = '0;
    c    = cin;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c;
      c       = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      cout[i] = c;
    end
  end

endmodule

// File: rtl/slice_serial_adder.sv
// Slice-serial adder: adds two N*W-bit operands one N-bit slice per clock
// through a single N-bit ripple-carry adder, carrying between slices in a
// register. One operation takes W RUN cycles plus the accept and release
// cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of slice_serial_adder_if (operand and result
//                handshakes, busy)
module slice_serial_adder
  import slice_serial_adder_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  slice_serial_adder_if.slave   bus
);

  localparam int unsigned OW = N * W;
  localparam int unsigned IW = idx_width(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [OW-1:0]   a_sh_q, a_sh_d;
  logic [OW-1:0]   b_sh_q, b_sh_d;
  logic [OW-1:0]   out_sum_q, out_sum_d;
  logic            out_cout_q, out_cout_d;
  logic            out_ovf_q, out_ovf_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    rca_a, rca_b, rca_sum, rca_cout;
  logic            rca_cin;
  logic            unused_cout_low;

  always_comb begin
    rca_a           = a_sh_q[N-1:0];
    rca_b           = b_sh_q[N-1:0];
    rca_cin         = carry_q;
    // Only the top two per-bit carries feed the datapath.
    unused_cout_low = ^rca_cout;
  end

  rca #(.N(N)) u_rca (
    .a    (rca_a),
    .b    (rca_b),
    .cin  (rca_cin),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_sh_d  = bus.in_a;
          b_sh_d  = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        out_sum_d[32'(idx_q) * N +: N] = rca_sum;
        carry_d = rca_cout[N-1];
        a_sh_d  = a_sh_q >> N;
        b_sh_d  = b_sh_q >> N;
        if (idx_q == LAST_IDX) begin
          out_cout_d = rca_cout[N-1];
          out_ovf_d  = rca_cout[N-1] ^ rca_cout[N-2];
          state_d    = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered copies of the next state.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.out_valid = out_valid_q;
    bus.out_sum   = out_sum_q;
    bus.out_cout  = out_cout_q;
    bus.out_ovf   = out_ovf_q;
    bus.busy      = busy_q;
  end

endmodule
